// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads have priority, CPU pixel writes are posted to a one-entry buffer.
// Latency: display read data valid 2 cycles after request; buffered write commits 1..1+STARVE_LIMIT cycles after accept.
// Backpressure: oCpuBusy is high while the buffer holds a write; the CPU holds its request until it is accepted.
module vram_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iCpuWrReq,
    input  logic [ADDR_WIDTH-1:0] iCpuAddr,
    input  logic [DATA_WIDTH-1:0] iCpuData,
    output logic                  oCpuBusy,
    output logic                  oCpuWrAck,
    input  logic                  iDispRdReq,
    input  logic [ADDR_WIDTH-1:0] iDispAddr,
    output logic [DATA_WIDTH-1:0] oDispData,
    output logic                  oDispValid,
    output logic                  oDispMiss,
    output logic [ADDR_WIDTH-1:0] oRamAddr,
    output logic [DATA_WIDTH-1:0] oRamData,
    output logic                  oRamWe,
    input  logic [DATA_WIDTH-1:0] iRamData
);

    typedef enum logic {EMPTY, PEND} state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   buf_addr;
    logic [DATA_WIDTH-1:0]   buf_data;
    logic [7:0]              starve_cnt;
    logic                    accept;
    logic                    cpu_grant;
    logic                    disp_grant;
    logic                    rd_vld_q;
    logic                    rd_miss_q;

    assign oCpuBusy = (state == PEND);

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        cpu_grant  = 1'b0;
        disp_grant = 1'b0;
        oRamWe     = 1'b0;
        oRamAddr   = '0;
        oRamData   = '0;

        case (state)
            EMPTY: begin
                // Accepted writes never commit in their accept cycle.
                accept = iCpuWrReq;
                if (accept) state_nxt = PEND;
            end
            PEND: begin
                cpu_grant = !iDispRdReq || (starve_cnt == LIMIT);
                if (cpu_grant) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase

        disp_grant = iDispRdReq && !cpu_grant;

        if (cpu_grant) begin
            oRamWe   = 1'b1;
            oRamAddr = buf_addr;
            oRamData = buf_data;
        end else if (disp_grant) begin
            oRamAddr = iDispAddr;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= EMPTY;
            buf_addr   <= '0;
            buf_data   <= '0;
            starve_cnt <= '0;
            oCpuWrAck  <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_miss_q  <= 1'b0;
            oDispValid <= 1'b0;
            oDispMiss  <= 1'b0;
            oDispData  <= '0;
        end else begin
            state     <= state_nxt;
            oCpuWrAck <= cpu_grant;
            if (accept) begin
                buf_addr <= iCpuAddr;
                buf_data <= iCpuData;
            end

            if (cpu_grant)
                starve_cnt <= '0;
            else if (disp_grant && state == PEND && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 8'd1;

            // A read that lost to a forced commit still returns a slot, flagged as a miss.
            rd_vld_q   <= iDispRdReq;
            rd_miss_q  <= iDispRdReq && cpu_grant;
            oDispValid <= rd_vld_q;
            oDispMiss  <= rd_miss_q;
            if (rd_vld_q && !rd_miss_q)
                oDispData <= iRamData;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_vram_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int LIMIT = 15;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          iCpuWrReq = 1'b0;
    logic [AW-1:0] iCpuAddr = '0;
    logic [DW-1:0] iCpuData = '0;
    logic          oCpuBusy, oCpuWrAck;
    logic          iDispRdReq = 1'b0;
    logic [AW-1:0] iDispAddr = '0;
    logic [DW-1:0] oDispData;
    logic          oDispValid, oDispMiss;
    logic [AW-1:0] oRamAddr;
    logic [DW-1:0] oRamData;
    logic          oRamWe;
    logic [DW-1:0] iRamData = '0;

    int checks = 0;
    int errors = 0;

    vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .Clock(Clock), .Reset(Reset),
        .iCpuWrReq(iCpuWrReq), .iCpuAddr(iCpuAddr), .iCpuData(iCpuData),
        .oCpuBusy(oCpuBusy), .oCpuWrAck(oCpuWrAck),
        .iDispRdReq(iDispRdReq), .iDispAddr(iDispAddr),
        .oDispData(oDispData), .oDispValid(oDispValid), .oDispMiss(oDispMiss),
        .oRamAddr(oRamAddr), .oRamData(oRamData), .oRamWe(oRamWe),
        .iRamData(iRamData)
    );

    always #5 Clock = ~Clock;

    // VRAM macro: synchronous, one-cycle read latency.
    bit [DW-1:0] vmem [0:65535];
    always @(posedge Clock) begin
        if (oRamWe) vmem[oRamAddr] <= oRamData;
        iRamData <= vmem[oRamAddr];
    end

    // Reference model: pending write, display wins waited, and a 2-deep queue of read outcomes.
    bit [DW-1:0]   ref_mem [0:65535];
    bit            m_pend, m_ack;
    int            m_wins;
    logic [AW-1:0] m_ba;
    logic [DW-1:0] m_bd;
    logic [DW-1:0] m_dout;
    bit            h_v [2];
    bit            h_m [2];
    logic [DW-1:0] h_d [2];

    logic          e_busy, e_ack, e_we, e_dv, e_dm;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdat, e_dd;

    task automatic tick(input bit rst, input bit wr, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input bit rd, input logic [AW-1:0] ra);
        bit cpu_w, disp_w;
        @(posedge Clock); #1;
        Reset = rst; iCpuWrReq = wr; iCpuAddr = wa; iCpuData = wd;
        iDispRdReq = rd; iDispAddr = ra;
        @(negedge Clock);
        cpu_w  = m_pend && (!rd || m_wins >= LIMIT);
        disp_w = rd && !cpu_w;
        e_busy = m_pend;
        e_ack  = m_ack;
        e_we   = cpu_w;
        e_addr = cpu_w ? m_ba : (disp_w ? ra : '0);
        e_wdat = cpu_w ? m_bd : '0;
        e_dv   = h_v[1];
        e_dm   = h_m[1];
        if (h_v[1] && !h_m[1]) m_dout = h_d[1];
        e_dd   = m_dout;
        h_v[1] = h_v[0]; h_m[1] = h_m[0]; h_d[1] = h_d[0];
        h_v[0] = rd;     h_m[0] = rd && cpu_w; h_d[0] = ref_mem[ra];
        m_ack  = cpu_w;
        if (cpu_w) begin
            ref_mem[m_ba] = m_bd;
            m_pend = 0;
            m_wins = 0;
        end else if (disp_w && m_pend) begin
            m_wins++;
        end
        if (!e_busy && wr) begin
            m_pend = 1; m_ba = wa; m_bd = wd; m_wins = 0;
        end
        if (rst) begin
            m_pend = 0; m_ack = 0; m_wins = 0; m_dout = '0;
            h_v[0] = 0; h_v[1] = 0; h_m[0] = 0; h_m[1] = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, '0, '0, 0, '0);
    endtask

    task automatic test_reset();
        tick(1, 0, '0, '0, 0, '0);
        tick(1, 0, '0, '0, 0, '0);
        tick(0, 1, 16'h0099, 8'hEE, 0, '0);
        tick(0, 0, '0, '0, 1, 16'h0001);
        tick(0, 0, '0, '0, 1, 16'h0002);
        tick(1, 0, '0, '0, 1, 16'h0003);
        tick(0, 0, '0, '0, 0, '0);
        checks++;
        if ({oCpuBusy, oCpuWrAck, oDispValid, oDispMiss, oRamWe} !== 5'b0 ||
            oRamAddr !== '0 || oRamData !== '0 || oDispData !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b ack=%b dv=%b dm=%b we=%b addr=%h wd=%h dd=%h want all 0",
                     oCpuBusy, oCpuWrAck, oDispValid, oDispMiss, oRamWe, oRamAddr, oRamData, oDispData);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, '0, '0, 0, '0);
            checks++;
            if (oCpuWrAck !== 1'b0 || oDispValid !== 1'b0 || oRamWe !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet cyc%0d got ack=%b dv=%b we=%b want 0 0 0", i, oCpuWrAck, oDispValid, oRamWe);
            end
        end
        checks++;
        if (vmem[16'h0099] !== 8'h00) begin
            errors++;
            $display("FAIL reset_no_commit got %h want 00", vmem[16'h0099]);
        end
    endtask

    task automatic test_lone_write();
        tick(0, 1, 16'h0021, 8'h04, 0, '0);
        checks++;
        if (oCpuBusy !== 1'b0 || oRamWe !== 1'b0) begin
            errors++;
            $display("FAIL lone_c0 got busy=%b we=%b want 0 0", oCpuBusy, oRamWe);
        end
        tick(0, 0, '0, '0, 0, '0);
        checks++;
        if (oRamWe !== 1'b1 || oRamAddr !== 16'h0021 || oRamData !== 8'h04 || oCpuBusy !== 1'b1 || oCpuWrAck !== 1'b0) begin
            errors++;
            $display("FAIL lone_c1 got we=%b addr=%h wd=%h busy=%b ack=%b want 1 0021 04 1 0",
                     oRamWe, oRamAddr, oRamData, oCpuBusy, oCpuWrAck);
        end
        tick(0, 0, '0, '0, 0, '0);
        checks++;
        if (oCpuWrAck !== 1'b1 || oCpuBusy !== 1'b0 || oRamWe !== 1'b0 || oRamData !== 8'h00) begin
            errors++;
            $display("FAIL lone_c2 got ack=%b busy=%b we=%b wd=%h want 1 0 0 00", oCpuWrAck, oCpuBusy, oRamWe, oRamData);
        end
        tick(0, 0, '0, '0, 0, '0);
        checks++;
        if (oCpuWrAck !== 1'b0 || vmem[16'h0021] !== 8'h04) begin
            errors++;
            $display("FAIL lone_c3 got ack=%b mem=%h want 0 04", oCpuWrAck, vmem[16'h0021]);
        end
    endtask

    task automatic test_read_pipeline();
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 16'(i), 8'(8'h10 + i), 0, '0);
            idle(2);
        end
        for (int k = 0; k < 6; k++) begin
            tick(0, 0, '0, '0, k < 4, 16'(k));
            checks++;
            if (oDispValid !== (k >= 2) || oDispMiss !== 1'b0 ||
                (k >= 2 && oDispData !== 8'(8'h10 + k - 2))) begin
                errors++;
                $display("FAIL rdpipe cyc%0d got dv=%b dm=%b dd=%h want %b 0 %h",
                         k, oDispValid, oDispMiss, oDispData, k >= 2, 8'(8'h10 + k - 2));
            end
        end
        idle(2);
    endtask

    task automatic test_display_priority();
        int commit_at = -1;
        int wins = 0;
        tick(0, 1, 16'h0040, 8'h5A, 0, '0);
        for (int k = 1; k <= 20; k++) begin
            tick(0, 0, '0, '0, 1, 16'(k % 4));
            if (oRamWe === 1'b1 && commit_at < 0) commit_at = k;
            if (commit_at < 0 && oRamWe === 1'b0 && oRamAddr === 16'(k % 4)) wins++;
            if (k == 18) begin
                checks++;
                if (oDispValid !== 1'b1 || oDispMiss !== 1'b1 || oDispData !== 8'h13) begin
                    errors++;
                    $display("FAIL prio_miss got dv=%b dm=%b dd=%h want 1 1 13", oDispValid, oDispMiss, oDispData);
                end
            end
            if (k == 19) begin
                checks++;
                if (oDispValid !== 1'b1 || oDispMiss !== 1'b0 || oDispData !== 8'h11) begin
                    errors++;
                    $display("FAIL prio_after got dv=%b dm=%b dd=%h want 1 0 11", oDispValid, oDispMiss, oDispData);
                end
            end
        end
        checks++;
        if (commit_at != 16 || wins != LIMIT) begin
            errors++;
            $display("FAIL prio_commit got cycle=%0d wins=%0d want 16 %0d", commit_at, wins, LIMIT);
        end
        idle(3);
        checks++;
        if (vmem[16'h0040] !== 8'h5A) begin
            errors++;
            $display("FAIL prio_mem got %h want 5a", vmem[16'h0040]);
        end
    endtask

    task automatic test_gap_commit();
        int commit_at = -1;
        tick(0, 1, 16'h0050, 8'h77, 0, '0);
        for (int k = 1; k <= 3; k++) tick(0, 0, '0, '0, 1, 16'(k - 1));
        tick(0, 0, '0, '0, 0, '0);
        checks++;
        if (oRamWe !== 1'b1 || oRamAddr !== 16'h0050 || oRamData !== 8'h77 || oDispValid !== 1'b1 || oDispMiss !== 1'b0) begin
            errors++;
            $display("FAIL gap_commit got we=%b addr=%h wd=%h dv=%b dm=%b want 1 0050 77 1 0",
                     oRamWe, oRamAddr, oRamData, oDispValid, oDispMiss);
        end
        tick(0, 1, 16'h0060, 8'h88, 1, 16'h0003);
        checks++;
        if (oCpuWrAck !== 1'b1 || oDispMiss !== 1'b0 || oDispData !== 8'h12) begin
            errors++;
            $display("FAIL gap_ack got ack=%b dm=%b dd=%h want 1 0 12", oCpuWrAck, oDispMiss, oDispData);
        end
        // A fresh write after the gap must again survive a full LIMIT of display wins.
        for (int k = 6; k <= 25; k++) begin
            tick(0, 0, '0, '0, 1, 16'(k % 4));
            if (oRamWe === 1'b1 && commit_at < 0) commit_at = k;
        end
        checks++;
        if (commit_at != 6 + LIMIT) begin
            errors++;
            $display("FAIL gap_counter_cleared got commit=%0d want %0d", commit_at, 6 + LIMIT);
        end
        idle(3);
    endtask

    task automatic test_busy_hold();
        tick(0, 1, 16'h0030, 8'hA1, 0, '0);
        tick(0, 1, 16'h0005, 8'hB2, 1, 16'h0001);
        checks++;
        if (oCpuBusy !== 1'b1 || oRamWe !== 1'b0) begin
            errors++;
            $display("FAIL hold_busy got busy=%b we=%b want 1 0", oCpuBusy, oRamWe);
        end
        tick(0, 1, 16'h0005, 8'hB2, 1, 16'h0002);
        tick(0, 1, 16'h0005, 8'hB2, 0, '0);
        checks++;
        if (oRamWe !== 1'b1 || oRamAddr !== 16'h0030 || oRamData !== 8'hA1) begin
            errors++;
            $display("FAIL hold_first got we=%b addr=%h wd=%h want 1 0030 a1", oRamWe, oRamAddr, oRamData);
        end
        tick(0, 1, 16'h0005, 8'hB2, 0, '0);
        checks++;
        if (oCpuWrAck !== 1'b1 || oCpuBusy !== 1'b0) begin
            errors++;
            $display("FAIL hold_ack got ack=%b busy=%b want 1 0", oCpuWrAck, oCpuBusy);
        end
        tick(0, 0, '0, '0, 0, '0);
        checks++;
        if (oRamWe !== 1'b1 || oRamAddr !== 16'h0005 || oRamData !== 8'hB2) begin
            errors++;
            $display("FAIL hold_second got we=%b addr=%h wd=%h want 1 0005 b2", oRamWe, oRamAddr, oRamData);
        end
        idle(2);
        checks++;
        if (vmem[16'h0030] !== 8'hA1 || vmem[16'h0005] !== 8'hB2) begin
            errors++;
            $display("FAIL hold_mem got %h %h want a1 b2", vmem[16'h0030], vmem[16'h0005]);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 600; c++) begin
            tick($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 63)),
                 8'($urandom), $urandom_range(0, 9) < 9, 16'($urandom_range(0, 63)));
            checks++;
            if (oCpuBusy !== e_busy || oCpuWrAck !== e_ack || oRamWe !== e_we ||
                oRamAddr !== e_addr || oRamData !== e_wdat) begin
                errors++;
                $display("FAIL rand_ram cyc%0d got busy=%b ack=%b we=%b addr=%h wd=%h want %b %b %b %h %h",
                         c, oCpuBusy, oCpuWrAck, oRamWe, oRamAddr, oRamData, e_busy, e_ack, e_we, e_addr, e_wdat);
            end
            checks++;
            if (oDispValid !== e_dv || oDispMiss !== e_dm || oDispData !== e_dd) begin
                errors++;
                $display("FAIL rand_disp cyc%0d got dv=%b dm=%b dd=%h want %b %b %h",
                         c, oDispValid, oDispMiss, oDispData, e_dv, e_dm, e_dd);
            end
        end
        idle(4);
        for (int a = 0; a < 65536; a++) if (vmem[a] !== ref_mem[a]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rand_mem_image got %0d differing bytes want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_lone_write();
        test_read_pipeline();
        test_display_priority();
        test_gap_commit();
        test_busy_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
